button_pulse_conditioner: RTL

Front-end stage that turns a raw, bouncing push-button into the clean `pulse` strobe consumed by the BCD counter / seven-segment stage. It synchronises the asynchronous button and debounces press and release. It emits exactly one registered, single-`clk`-cycle pulse per accepted press, with optional auto-repeat while the button is held. It also exports the debounced button level for LEDs or other consumers.

---
 rtl/button_pkg.sv | 28 ++
 rtl/button_pulse_conditioner_if.sv | 9 +
 rtl/sync_2ff.sv | 23 ++
 rtl/button_pulse_conditioner.sv | 134 +++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared definitions for the push-button front end: FSM state encoding,
// default timing parameters and a small sizing helper.
package button_pkg;

  localparam logic [1:0] S_IDLE         = 2'd0;
  localparam logic [1:0] S_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] S_HELD         = 2'd2;
  localparam logic [1:0] S_RELEASE_WAIT = 2'd3;

  typedef enum logic [1:0] {
    IDLE         = S_IDLE,
    PRESS_WAIT   = S_PRESS_WAIT,
    HELD         = S_HELD,
    RELEASE_WAIT = S_RELEASE_WAIT
  } btn_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_REPEAT_EN       = 0;
  localparam int DEF_REPEAT_DELAY    = 20;
  localparam int DEF_REPEAT_PERIOD   = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/button_pulse_conditioner_if.sv
// Button-side signal bundle: raw button in, conditioned strobe and level out.
interface button_pulse_conditioner_if;
  logic btn_in;
  logic pulse;
  logic btn_level;

  modport master (output btn_in, input pulse, input btn_level);
  modport slave  (input btn_in, output pulse, output btn_level);
endinterface

// File: rtl/sync_2ff.sv
// Plain two-flop synchroniser for asynchronous button/switch inputs.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1;

  // NOTE: non-blocking assignments make s1 and q shift as a true two-stage
  // pipeline; blocking here would collapse them into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/button_pulse_conditioner.sv
// Debounces a raw push-button and emits one registered pulse per accepted
// press, with optional auto-repeat while held, plus the debounced level.
module button_pulse_conditioner
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_EN       = DEF_REPEAT_EN,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input logic                        clk,
  input logic                        rst_n,
  button_pulse_conditioner_if.slave  io
);

  localparam int CNT_MAX = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t CNT_SAT = cnt_t'(CNT_MAX);
  localparam cnt_t DB_LAST = cnt_t'(DEBOUNCE_CYCLES - 1);
  localparam cnt_t RD_LAST = cnt_t'(REPEAT_DELAY - 1);
  localparam cnt_t RP_LAST = cnt_t'(REPEAT_PERIOD - 1);

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == CNT_SAT) ? v : v + cnt_t'(1);
  endfunction

  logic       btn_sync;
  btn_state_t state_q, state_d;
  cnt_t       db_cnt_q, db_cnt_d;
  cnt_t       rep_cnt_q, rep_cnt_d;
  logic       rep_armed_q, rep_armed_d;
  logic       pulse_q, pulse_d;
  logic       level_q, level_d;
  cnt_t       rep_last;
  logic       rep_hit;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (io.btn_in),
    .q     (btn_sync)
  );

  // The first repeat waits REPEAT_DELAY cycles; once armed, REPEAT_PERIOD.
  assign rep_last = rep_armed_q ? RP_LAST : RD_LAST;
  assign rep_hit  = (REPEAT_EN != 0) && (rep_cnt_q == rep_last);

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    db_cnt_d    = db_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    rep_armed_d = rep_armed_q;
    pulse_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (btn_sync) begin
          state_d  = PRESS_WAIT;
          db_cnt_d = cnt_t'(1);
        end
      end

      PRESS_WAIT: begin
        if (!btn_sync) begin
          state_d = IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          state_d     = HELD;
          pulse_d     = 1'b1;
          rep_cnt_d   = '0;
          rep_armed_d = 1'b0;
        end else begin
          db_cnt_d = sat_inc(db_cnt_q);
        end
      end

      HELD: begin
        if (!btn_sync) begin
          state_d  = RELEASE_WAIT;
          db_cnt_d = cnt_t'(1);
        end else if (rep_hit) begin
          pulse_d     = 1'b1;
          rep_cnt_d   = '0;
          rep_armed_d = 1'b1;
        end else begin
          rep_cnt_d = sat_inc(rep_cnt_q);
        end
      end

      RELEASE_WAIT: begin
        if (btn_sync) begin
          // Release bounce: back to held silently, repeat timing restarts.
          state_d     = HELD;
          rep_cnt_d   = '0;
          rep_armed_d = 1'b0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d = IDLE;
        end else begin
          db_cnt_d = sat_inc(db_cnt_q);
        end
      end

      default: state_d = IDLE;
    endcase

    level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      db_cnt_q    <= '0;
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b0;
      pulse_q     <= 1'b0;
      level_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      rep_armed_q <= rep_armed_d;
      pulse_q     <= pulse_d;
      level_q     <= level_d;
    end
  end

  assign io.pulse     = pulse_q;
  assign io.btn_level = level_q;

endmodule
